// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one asynchronous SRAM among four request queues.
// Each grant runs IDLE -> ACCESS -> DONE with registered SRAM strobes.
module sram_arbiter #(
  parameter int unsigned PORTS  = 4,
  parameter int unsigned ADDR_W = 20,
  parameter int unsigned DATA_W = 16
) (
  input  logic                      SRAM_CLK,
  input  logic                      RESET_N,
  input  logic [PORTS-1:0]          ReadReq,
  input  logic [PORTS-1:0]          WriteReq,
  input  logic [PORTS*ADDR_W-1:0]   Address,
  input  logic [PORTS*DATA_W-1:0]   WriteData,
  output logic [PORTS-1:0]          Ack,
  output logic [DATA_W-1:0]         ReadData,
  output logic                      Busy,
  output logic [ADDR_W-1:0]         SRAM_ADDR,
  inout  logic [DATA_W-1:0]         SRAM_DQ,
  output logic                      SRAM_CE_N,
  output logic                      SRAM_OE_N,
  output logic                      SRAM_WE_N,
  output logic                      SRAM_UB_N,
  output logic                      SRAM_LB_N
);

  localparam int unsigned PTR_W = $clog2(PORTS);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state_q;
  logic [PTR_W-1:0]    ptr_q;
  logic [PTR_W-1:0]    win_q;
  logic                op_wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                dq_oe_q;
  logic [PORTS-1:0]    ack_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                ce_n_q;
  logic                oe_n_q;
  logic                we_n_q;
  logic                bs_n_q;

  logic [PORTS-1:0]    req;
  logic                win_found;
  logic [PTR_W-1:0]    win_idx;
  logic [PTR_W-1:0]    idx;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_data;
  logic                win_wr;

  assign req = ReadReq | WriteReq;

  // Search ptr, ptr+1, ... with natural wrap of the pointer width (PORTS is a power of two).
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      idx = ptr_q + PTR_W'(i);
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      if (PTR_W'(i) == win_idx) begin
        win_addr = Address[i*ADDR_W +: ADDR_W];
        win_data = WriteData[i*DATA_W +: DATA_W];
      end
    end
  end

  // A port raising both requests gets the write only.
  assign win_wr = WriteReq[win_idx];

  always_ff @(posedge SRAM_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      dq_oe_q <= 1'b0;
      ack_q   <= '0;
      rdata_q <= '0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      bs_n_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= '0;
          if (win_found) begin
            win_q   <= win_idx;
            addr_q  <= win_addr;
            wdata_q <= win_data;
            op_wr_q <= win_wr;
            dq_oe_q <= win_wr;
            ce_n_q  <= 1'b0;
            bs_n_q  <= 1'b0;
            oe_n_q  <= win_wr;
            we_n_q  <= ~win_wr;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (!op_wr_q) begin
            rdata_q <= SRAM_DQ;
          end
          // CE, address and write data stay put through DONE for hold after WE rises.
          oe_n_q  <= 1'b1;
          we_n_q  <= 1'b1;
          ack_q   <= PORTS'(1) << win_q;
          state_q <= DONE;
        end
        DONE: begin
          ack_q   <= '0;
          ce_n_q  <= 1'b1;
          bs_n_q  <= 1'b1;
          dq_oe_q <= 1'b0;
          ptr_q   <= win_q + PTR_W'(1);
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Ack       = ack_q;
  assign ReadData  = rdata_q;
  assign Busy      = (state_q != IDLE);
  assign SRAM_ADDR = addr_q;
  assign SRAM_DQ   = dq_oe_q ? wdata_q : 'z;
  assign SRAM_CE_N = ce_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_UB_N = bs_n_q;
  assign SRAM_LB_N = bs_n_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: directed requests with an async SRAM model;
// a negedge monitor checks Acks/ReadData against the queue plus per-cycle pin probes.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  rreq;
  logic [3:0]  wreq;
  logic [79:0] addr;
  logic [63:0] wdata;
  logic [3:0]  ack;
  logic [15:0] rdata;
  logic        busy;
  logic [19:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        ce_n, oe_n, we_n, ub_n, lb_n;

  always #5 clk = ~clk;

  sram_arbiter #(.PORTS(4), .ADDR_W(20), .DATA_W(16)) dut (
    .SRAM_CLK (clk),
    .RESET_N  (rst_n),
    .ReadReq  (rreq),
    .WriteReq (wreq),
    .Address  (addr),
    .WriteData(wdata),
    .Ack      (ack),
    .ReadData (rdata),
    .Busy     (busy),
    .SRAM_ADDR(sram_addr),
    .SRAM_DQ  (sram_dq),
    .SRAM_CE_N(ce_n),
    .SRAM_OE_N(oe_n),
    .SRAM_WE_N(we_n),
    .SRAM_UB_N(ub_n),
    .SRAM_LB_N(lb_n)
  );

  // SRAM model: unwritten locations read as the inverted low 16 address bits.
  logic [15:0] mem [logic [19:0]];
  logic [15:0] rd_word = '0;
  always @(negedge clk) begin
    if (!ce_n && !we_n) mem[sram_addr] = sram_dq;
    rd_word = mem.exists(sram_addr) ? mem[sram_addr] : ~sram_addr[15:0];
  end
  assign sram_dq = (!ce_n && !oe_n && we_n) ? rd_word : 'z;

  localparam logic [4:0] S_IDLE = 5'b11111;  // {ce,oe,we,ub,lb}
  localparam logic [4:0] S_RD   = 5'b00100;
  localparam logic [4:0] S_WR   = 5'b01000;
  localparam logic [4:0] S_DONE = 5'b01100;

  typedef struct {
    logic [3:0]  mask;
    logic        is_rd;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    int unsigned cyc;
    string       name;
    logic [4:0]  strb;
    logic        busy;
    logic [3:0]  ack;
    logic        chk_addr;
    logic [19:0] addr;
    logic        chk_dq;
    logic [15:0] dq;
    logic        chk_rd;
    logic [15:0] rd;
  } probe_t;

  exp_t        sb[$];
  probe_t      pq[$];
  int unsigned cyc      = 0;
  int unsigned deadline = 32'hFFFF_FFFF;
  int unsigned n_chk    = 0;
  int unsigned n_fail   = 0;
  exp_t        e;
  probe_t      p;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (ack != 4'b0000) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_ack actual=%b required=0000 (cycle %0d)", ack, cyc);
      end else begin
        e = sb.pop_front();
        chk("ack_port", 32'(ack), 32'(e.mask));
        if (e.is_rd) chk("read_data", 32'(rdata), 32'(e.data));
      end
    end
    while (pq.size() != 0 && pq[0].cyc == cyc) begin
      p = pq.pop_front();
      chk({p.name, "/strobes"}, 32'({ce_n, oe_n, we_n, ub_n, lb_n}), 32'(p.strb));
      chk({p.name, "/busy"}, 32'(busy), 32'(p.busy));
      chk({p.name, "/ack"}, 32'(ack), 32'(p.ack));
      if (p.chk_addr) chk({p.name, "/addr"}, 32'(sram_addr), 32'(p.addr));
      if (p.chk_dq)   chk({p.name, "/dq"}, 32'(sram_dq), 32'(p.dq));
      if (p.chk_rd)   chk({p.name, "/rdata"}, 32'(rdata), 32'(p.rd));
    end
    if (cyc == deadline && sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL ack_timeout actual=%0d_pending required=0_pending", sb.size());
      sb.delete();
    end
    cyc++;
  end

  logic [3:0] ack_n;
  logic [3:0] keep;
  logic [3:0] drop;
  int unsigned nack = 0;

  task automatic probe(input int unsigned off, input string nm, input logic [4:0] s,
                       input logic b, input logic [3:0] a,
                       input logic ca, input logic [19:0] ad,
                       input logic cd, input logic [15:0] d,
                       input logic cr, input logic [15:0] r);
    probe_t t;
    t.cyc = cyc + off; t.name = nm; t.strb = s; t.busy = b; t.ack = a;
    t.chk_addr = ca; t.addr = ad; t.chk_dq = cd; t.dq = d; t.chk_rd = cr; t.rd = r;
    pq.push_back(t);
  endtask

  task automatic expect_ack(input logic [3:0] m, input logic rd, input logic [15:0] d);
    exp_t t;
    t.mask = m; t.is_rd = rd; t.data = d;
    sb.push_back(t);
  endtask

  // Requesters drop their request in the cycle after their Ack unless told to keep it.
  task automatic tick();
    @(negedge clk);
    ack_n = ack;
    @(posedge clk);
    #1;
    drop = ack_n & ~keep;
    rreq = rreq & ~drop;
    wreq = wreq & ~drop;
    nack += $countones(ack_n);
  endtask

  task automatic drain(input int unsigned budget);
    deadline = cyc + budget;
    for (int unsigned k = 0; k < budget + 2; k++) begin
      if (sb.size() == 0 && pq.size() == 0) break;
      tick();
    end
  endtask

  task automatic set_port(input int pt, input logic rd, input logic wr,
                          input logic [19:0] a, input logic [15:0] d);
    rreq[pt] = rd;
    wreq[pt] = wr;
    addr[pt*20 +: 20]  = a;
    wdata[pt*16 +: 16] = d;
  endtask

  initial begin
    rst_n = 1'b0; rreq = '0; wreq = '0; addr = '0; wdata = '0; keep = '0;
    ack_n = '0; drop = '0;
    repeat (2) @(posedge clk);
    #1;
    probe(0, "reset", S_IDLE, 1'b0, 4'b0000, 1'b1, 20'h0, 1'b0, 16'h0, 1'b1, 16'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Four simultaneous reads, served 0..3 three cycles apart.
    for (int i = 0; i < 4; i++) set_port(i, 1'b1, 1'b0, 20'(i + 1), 16'h0);
    expect_ack(4'b0001, 1'b1, 16'hFFFE);
    expect_ack(4'b0010, 1'b1, 16'hFFFD);
    expect_ack(4'b0100, 1'b1, 16'hFFFC);
    expect_ack(4'b1000, 1'b1, 16'hFFFB);
    probe(1,  "four_acc0",  S_RD,   1'b1, 4'b0000, 1'b1, 20'h1, 1'b0, 16'h0, 1'b0, 16'h0);
    probe(2,  "four_done0", S_DONE, 1'b1, 4'b0001, 1'b1, 20'h1, 1'b0, 16'h0, 1'b1, 16'hFFFE);
    probe(3,  "four_gap",   S_IDLE, 1'b0, 4'b0000, 1'b1, 20'h1, 1'b0, 16'h0, 1'b0, 16'h0);
    probe(5,  "four_done1", S_DONE, 1'b1, 4'b0010, 1'b1, 20'h2, 1'b0, 16'h0, 1'b1, 16'hFFFD);
    probe(8,  "four_done2", S_DONE, 1'b1, 4'b0100, 1'b1, 20'h3, 1'b0, 16'h0, 1'b1, 16'hFFFC);
    probe(11, "four_done3", S_DONE, 1'b1, 4'b1000, 1'b1, 20'h4, 1'b0, 16'h0, 1'b1, 16'hFFFB);
    drain(20);

    // Single read, port 0.
    set_port(0, 1'b1, 1'b0, 20'h00F0F, 16'h0);
    expect_ack(4'b0001, 1'b1, 16'hF0F0);
    probe(0, "rd_idle", S_IDLE, 1'b0, 4'b0000, 1'b0, 20'h0, 1'b0, 16'h0, 1'b0, 16'h0);
    probe(1, "rd_acc",  S_RD,   1'b1, 4'b0000, 1'b1, 20'h00F0F, 1'b0, 16'h0, 1'b0, 16'h0);
    probe(2, "rd_done", S_DONE, 1'b1, 4'b0001, 1'b1, 20'h00F0F, 1'b0, 16'h0, 1'b1, 16'hF0F0);
    drain(10);

    // Single write, port 3.
    set_port(3, 1'b0, 1'b1, 20'h0F0F0, 16'hF0F0);
    expect_ack(4'b1000, 1'b0, 16'h0);
    probe(1, "wr_acc",  S_WR,   1'b1, 4'b0000, 1'b1, 20'h0F0F0, 1'b1, 16'hF0F0, 1'b0, 16'h0);
    probe(2, "wr_done", S_DONE, 1'b1, 4'b1000, 1'b1, 20'h0F0F0, 1'b1, 16'hF0F0, 1'b0, 16'h0);
    probe(3, "wr_idle", S_IDLE, 1'b0, 4'b0000, 1'b1, 20'h0F0F0, 1'b0, 16'h0, 1'b0, 16'h0);
    drain(10);

    // Read and write together on port 1: write only.
    set_port(1, 1'b1, 1'b1, 20'h00100, 16'h0FF0);
    expect_ack(4'b0010, 1'b0, 16'h0);
    probe(1, "rw_acc",  S_WR,   1'b1, 4'b0000, 1'b1, 20'h00100, 1'b1, 16'h0FF0, 1'b0, 16'h0);
    probe(2, "rw_done", S_DONE, 1'b1, 4'b0010, 1'b1, 20'h00100, 1'b1, 16'h0FF0, 1'b0, 16'h0);
    probe(4, "rw_after", S_IDLE, 1'b0, 4'b0000, 1'b0, 20'h0, 1'b0, 16'h0, 1'b0, 16'h0);
    drain(10);

    // Read back the port-3 write through the arbiter.
    set_port(3, 1'b1, 1'b0, 20'h0F0F0, 16'h0);
    expect_ack(4'b1000, 1'b1, 16'hF0F0);
    probe(2, "rb_done", S_DONE, 1'b1, 4'b1000, 1'b1, 20'h0F0F0, 1'b0, 16'h0, 1'b1, 16'hF0F0);
    drain(10);

    // Fairness: ports 0 and 2 held continuously alternate.
    keep = 4'b0101;
    set_port(0, 1'b1, 1'b0, 20'h00010, 16'h0);
    set_port(2, 1'b1, 1'b0, 20'h00020, 16'h0);
    for (int i = 0; i < 3; i++) begin
      expect_ack(4'b0001, 1'b1, 16'hFFEF);
      expect_ack(4'b0100, 1'b1, 16'hFFDF);
    end
    for (int i = 0; i < 6; i++)
      probe(32'(2 + 3 * i), "fair", S_DONE, 1'b1, (i % 2 == 0) ? 4'b0001 : 4'b0100,
            1'b0, 20'h0, 1'b0, 16'h0, 1'b0, 16'h0);
    begin
      int unsigned base;
      base = nack;
      deadline = cyc + 30;
      for (int k = 0; k < 30 && nack < base + 5; k++) tick();
    end
    rreq[0] = 1'b0;
    keep = '0;
    drain(10);

    // Reset in the middle of a port-2 write ACCESS.
    set_port(2, 1'b0, 1'b1, 20'h00200, 16'h1234);
    probe(1, "rst_abort", S_IDLE, 1'b0, 4'b0000, 1'b1, 20'h0, 1'b0, 16'h0, 1'b1, 16'h0);
    probe(2, "rst_hold",  S_IDLE, 1'b0, 4'b0000, 1'b1, 20'h0, 1'b0, 16'h0, 1'b1, 16'h0);
    tick();
    #1;
    rst_n = 1'b0;
    rreq = '0;
    wreq = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Pointer back at 0: port 1 wins over port 3.
    set_port(1, 1'b1, 1'b0, 20'h00301, 16'h0);
    set_port(3, 1'b1, 1'b0, 20'h00303, 16'h0);
    expect_ack(4'b0010, 1'b1, 16'hFCFE);
    expect_ack(4'b1000, 1'b1, 16'hFCFC);
    probe(2, "post_rst1", S_DONE, 1'b1, 4'b0010, 1'b1, 20'h00301, 1'b0, 16'h0, 1'b1, 16'hFCFE);
    probe(5, "post_rst3", S_DONE, 1'b1, 4'b1000, 1'b1, 20'h00303, 1'b0, 16'h0, 1'b1, 16'hFCFC);
    drain(15);

    // The aborted write must not have reached the SRAM.
    set_port(0, 1'b1, 1'b0, 20'h00200, 16'h0);
    expect_ack(4'b0001, 1'b1, 16'hFDFF);
    drain(10);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
